// File: rtl/audio_pkg.sv
// Shared constants and helpers for the audio sample sink: midscale value,
// packed-sample field slicing and the phase accumulator width.
package audio_pkg;

  localparam int AUDIO_PH_W = 32;

  function automatic int AUDIO_MIDSCALE(input int w);
    return 1 << (w - 1);
  endfunction

  // Packed sample layout: left channel in the upper W bits, right in the lower W.
  function automatic logic [31:0] audio_left(input logic [63:0] s, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return 32'((s >> w) & m);
  endfunction

  function automatic logic [31:0] audio_right(input logic [63:0] s, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return 32'(s & m);
  endfunction

endpackage

// File: rtl/audio_dsm_1bit.sv
// First-order 1-bit delta-sigma modulator; the output bit is the carry of a
// free-running accumulator, so its density tracks din / 2^AUDIO_BITS.
module audio_dsm_1bit #(
  parameter int AUDIO_BITS = 12
) (
  input  logic                  clk,
  input  logic                  aclr_,
  input  logic [AUDIO_BITS-1:0] din,
  output logic                  dout
);

  logic [AUDIO_BITS:0] r_acc;

  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_) r_acc <= '0;
    else        r_acc <= {1'b0, r_acc[AUDIO_BITS-1:0]} + {1'b0, din};
  end

  assign dout = r_acc[AUDIO_BITS];

endmodule

// File: rtl/audio_sample_sink.sv
// Stereo sample sink: small FIFO, fractional-rate pop pacing, one delta-sigma
// modulator per channel. AUDIO_SINK_UNDERRUN_MUTE_EN loads midscale on underrun.
module audio_sample_sink import audio_pkg::*; #(
  parameter int AUDIO_BITS = 12,
  parameter int CLK_HZ     = 50000000,
  parameter int SAMPLE_HZ  = 44100,
  parameter int FIFO_LOG2  = 3
) (
  input  logic                    clk,
  input  logic                    aclr_,
  input  logic                    wreq,
  input  logic [2*AUDIO_BITS-1:0] sample,
  input  logic                    clr_flags,
  output logic                    ready,
  output logic                    left_out,
  output logic                    right_out,
  output logic [FIFO_LOG2:0]      level,
  output logic                    underrun,
  output logic                    overflow
);

  localparam int W     = AUDIO_BITS;
  localparam int DEPTH = 1 << FIFO_LOG2;

  typedef logic [FIFO_LOG2:0]   ptr_t;
  typedef logic [AUDIO_PH_W:0]  ph_ext_t;
  typedef logic [2*W-1:0]       smp_t;

  localparam logic [W-1:0] MID     = W'(AUDIO_MIDSCALE(W));
  localparam ph_ext_t      CLK_C   = ph_ext_t'(CLK_HZ);
  localparam ph_ext_t      STEP_C  = ph_ext_t'(SAMPLE_HZ);
  localparam ptr_t         RDY_MAX = ptr_t'(DEPTH - 2);

  smp_t                  r_mem [DEPTH];
  ptr_t                  r_wptr, r_rptr;
  logic [AUDIO_PH_W-1:0] r_ph;
  logic [W-1:0]          r_cur_l, r_cur_r;
  logic                  r_primed, r_ready, r_underrun, r_overflow;

  ptr_t    w_level, w_level_nx;
  logic    w_full, w_empty, w_push, w_pop, w_drop, w_und, w_tick;
  ph_ext_t w_ph_sum;
  smp_t    w_head;
  logic [W-1:0] w_head_l, w_head_r;

  // Rate generator: exact SAMPLE_HZ ticks per CLK_HZ cycles.
  assign w_ph_sum = {1'b0, r_ph} + STEP_C;
  assign w_tick   = (w_ph_sum >= CLK_C);

  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_)      r_ph <= '0;
    else if (w_tick) r_ph <= AUDIO_PH_W'(w_ph_sum - CLK_C);
    else             r_ph <= w_ph_sum[AUDIO_PH_W-1:0];
  end

  // FIFO state; fullness is judged on the pre-pop level.
  assign w_level = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[FIFO_LOG2] != r_rptr[FIFO_LOG2]) &&
                   (r_wptr[FIFO_LOG2-1:0] == r_rptr[FIFO_LOG2-1:0]);
  assign w_push  = wreq & ~w_full;
  assign w_drop  = wreq & w_full;
  assign w_pop   = w_tick & ~w_empty;
  assign w_und   = w_tick & w_empty & r_primed;

  assign w_level_nx = w_level + ptr_t'(w_push) - ptr_t'(w_pop);

  assign w_head   = r_mem[r_rptr[FIFO_LOG2-1:0]];
  assign w_head_l = W'(audio_left(64'(w_head), W));
  assign w_head_r = W'(audio_right(64'(w_head), W));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[FIFO_LOG2-1:0]] <= sample;
  end

  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_ready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + ptr_t'(1);
      if (w_pop)  r_rptr <= r_rptr + ptr_t'(1);
      r_ready <= (w_level_nx <= RDY_MAX);
    end
  end

  // Current output sample per channel.
  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_) begin
      r_cur_l  <= '0;
      r_cur_r  <= '0;
      r_primed <= 1'b0;
    end else if (w_pop) begin
      r_cur_l  <= w_head_l;
      r_cur_r  <= w_head_r;
      r_primed <= 1'b1;
    end else if (w_und) begin
`ifdef AUDIO_SINK_UNDERRUN_MUTE_EN
      r_cur_l  <= MID;
      r_cur_r  <= MID;
`else
      r_cur_l  <= r_cur_l;
      r_cur_r  <= r_cur_r;
`endif
    end
  end

  // Sticky flags: a set in the same cycle as clr_flags wins.
  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_) begin
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_und)          r_underrun <= 1'b1;
      else if (clr_flags) r_underrun <= 1'b0;
      if (w_drop)         r_overflow <= 1'b1;
      else if (clr_flags) r_overflow <= 1'b0;
    end
  end

  audio_dsm_1bit #(.AUDIO_BITS(W)) u_dsm_l (
    .clk  (clk),
    .aclr_(aclr_),
    .din  (r_cur_l),
    .dout (left_out)
  );

  audio_dsm_1bit #(.AUDIO_BITS(W)) u_dsm_r (
    .clk  (clk),
    .aclr_(aclr_),
    .din  (r_cur_r),
    .dout (right_out)
  );

  assign ready    = r_ready;
  assign level    = w_level;
  assign underrun = r_underrun;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_audio_sample_sink.sv
// Directed bench for audio_sample_sink at CLK_HZ=100, SAMPLE_HZ=10 (one tick per 10 clocks).
module tb_audio_sample_sink;

  localparam int W = 12;

  logic           clk = 1'b0;
  logic           aclr_ = 1'b0;
  logic           wreq = 1'b0;
  logic           clr_flags = 1'b0;
  logic [2*W-1:0] sample = '0;
  logic           ready, left_out, right_out, underrun, overflow;
  logic [3:0]     level;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  audio_sample_sink #(
    .AUDIO_BITS(W), .CLK_HZ(100), .SAMPLE_HZ(10), .FIFO_LOG2(3)
  ) dut (
    .clk      (clk),
    .aclr_    (aclr_),
    .wreq     (wreq),
    .sample   (sample),
    .clr_flags(clr_flags),
    .ready    (ready),
    .left_out (left_out),
    .right_out(right_out),
    .level    (level),
    .underrun (underrun),
    .overflow (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stops just before an edge on which a tick will occur.
  task automatic wait_pre_tick(input string tag);
    int n;
    n = 0;
    while (dut.w_tick !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) chk(tag, 32'(n), 32'(39));
  endtask

  task automatic wait_tick(input string tag);
    wait_pre_tick(tag);
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    wreq = 1'b0; clr_flags = 1'b0; aclr_ = 1'b0;
    #1;
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_outs", 32'({ready, left_out, right_out, underrun, overflow}), 32'(0));
    repeat (2) step();
    @(negedge clk);
    aclr_ = 1'b1;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic        bad;
    int          cyc, lastl, pbad, ones_l, ones_r, cnt, npop, lbad;
    logic [7:0]  pat_l, pat_r;
    logic        up, seen, pt;
    logic [3:0]  pl;
    logic [23:0] q[$];

    // Reset and idle
    repeat (5) begin
      step();
      chk("rst_hold", 32'({ready, left_out, right_out, underrun, overflow, level}), 32'(0));
    end
    @(negedge clk);
    aclr_ = 1'b1;
    #1;
    chk("rdy_before_edge", 32'(ready), 32'(0));
    step();
    chk("rdy_after_edge", 32'(ready), 32'(1));
    bad = 1'b0;
    repeat (100) begin
      step();
      bad = bad | left_out | right_out | underrun | overflow;
    end
    chk("idle_quiet", 32'(bad), 32'(0));
    chk("idle_level", 32'(level), 32'(0));

    // Pacing and overflow: fill right after a tick so no pop interferes
    wait_tick("sync");
    wreq = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample = {12'(32'h100 + i), 12'(32'h200 + i)};
      step();
      chk("fill_level", 32'(level), 32'(i + 1));
      chk("fill_ready", 32'(ready), 32'((i + 1) <= 6));
    end
    sample = 24'h1FF1FF;
    step();
    chk("ovf_level", 32'(level), 32'(8));
    chk("ovf_flag", 32'(overflow), 32'(1));
    wreq = 1'b0;
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'(0));
    chk("pop1_level", 32'(level), 32'(7));
    chk("pop1_cur", 32'(dut.r_cur_l), 32'(12'h100));
    cyc = 10; lastl = 7; pbad = 0;
    while (level != 4'd0 && cyc < 120) begin
      step();
      cyc++;
      if (32'(level) != lastl) begin
        if ((cyc % 10) != 0 || 32'(level) != lastl - 1) pbad++;
        lastl = 32'(level);
      end
      if (ready != (level <= 4'd6)) pbad++;
    end
    chk("drain_cycles", 32'(cyc), 32'(80));
    chk("drain_spacing", 32'(pbad), 32'(0));
    chk("drain_last", 32'({dut.r_cur_l, dut.r_cur_r}), 32'(24'h107207));

    // Modulator at midscale, zero and full scale
    do_reset();
    wreq = 1'b1; sample = 24'h800800;
    step();
    wreq = 1'b0;
    wait_tick("m_mid");
    chk("m_mid_cur", 32'(dut.r_cur_l), 32'(12'h800));
    pat_l = '0; pat_r = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      pat_l = {pat_l[6:0], left_out};
      pat_r = {pat_r[6:0], right_out};
    end
    chk("dsm_mid_l", 32'(pat_l), 32'(8'h55));
    chk("dsm_mid_r", 32'(pat_r), 32'(8'h55));
    wreq = 1'b1; sample = 24'h000000;
    step();
    wreq = 1'b0;
    wait_tick("m_zero");
    step();
    pat_l = '0; pat_r = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      pat_l = pat_l | {7'd0, left_out};
      pat_r = pat_r | {7'd0, right_out};
    end
    chk("dsm_zero", 32'({pat_l, pat_r}), 32'(0));
    wreq = 1'b1; sample = 24'hFFFFFF;
    step();
    wreq = 1'b0;
    wait_tick("m_full");
    ones_l = 0; ones_r = 0;
    for (int i = 0; i < 4096; i++) begin
      wreq = (level < 4'd4);
      step();
      ones_l += int'(left_out);
      ones_r += int'(right_out);
    end
    wreq = 1'b0;
    chk("dsm_full_l", 32'(ones_l), 32'(4095));
    chk("dsm_full_r", 32'(ones_r), 32'(4095));

    // Underrun after two samples; reset here also discards a non-empty FIFO
    do_reset();
    wreq = 1'b1; sample = 24'h123456;
    step();
    sample = 24'hABC789;
    step();
    wreq = 1'b0;
    wait_tick("u1");
    chk("u1_cur", 32'({dut.r_cur_l, dut.r_cur_r}), 32'(24'h123456));
    chk("u1_flag", 32'(underrun), 32'(0));
    wait_tick("u2");
    chk("u2_cur", 32'({dut.r_cur_l, dut.r_cur_r}), 32'(24'hABC789));
    chk("u2_flag", 32'(underrun), 32'(0));
    wait_tick("u3");
    chk("u3_flag", 32'(underrun), 32'(1));
`ifdef AUDIO_SINK_UNDERRUN_MUTE_EN
    chk("u3_cur", 32'({dut.r_cur_l, dut.r_cur_r}), 32'(24'h800800));
`else
    chk("u3_cur", 32'({dut.r_cur_l, dut.r_cur_r}), 32'(24'hABC789));
`endif
    wait_pre_tick("u4");
    clr_flags = 1'b1;
    step();
    chk("clr_set_wins", 32'(underrun), 32'(1));
    step();
    clr_flags = 1'b0;
    chk("clr_underrun", 32'(underrun), 32'(0));

    // Producer loopback with up/down counting samples
    do_reset();
    cnt = 0; up = 1'b1; seen = 1'b0; pt = 1'b0; pl = '0; npop = 0; lbad = 0;
    for (int i = 0; i < 10000; i++) begin
      if (pt && pl != 4'd0) begin
        npop++;
        if (q.size() > 0 && {dut.r_cur_l, dut.r_cur_r} == q[0]) void'(q.pop_front());
        else lbad++;
      end
      pt = dut.w_tick;
      pl = level;
      wreq = seen;
      sample = {12'(cnt), 12'(cnt) ^ 12'hFFF};
      if (wreq) begin
        if (level < 4'd8) q.push_back(sample);
        if (up) begin cnt++; if (cnt == 200) up = 1'b0; end
        else    begin cnt--; if (cnt == 0)   up = 1'b1; end
      end
      seen = ready;
      step();
    end
    wreq = 1'b0;
    chk("lb_overflow", 32'(overflow), 32'(0));
    chk("lb_sequence", 32'(lbad), 32'(0));
    chk("lb_pops", 32'(npop >= 990), 32'(1));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
